// File: rtl/filter_stream_pkg.sv
// -----------------------------------------------------------------------------
// filter_stream_pkg
// Shared types and helpers for the pixel-filter stream driver.
//   fsd_state_t : driver FSM state encoding
//   DEF_PIX_W   : default pixel width
//   ptr_w()     : pointer/counter width able to hold the value DEPTH itself
// -----------------------------------------------------------------------------
package filter_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PROC = 2'd2,
    ST_DONE = 2'd3
  } fsd_state_t;

  localparam int DEF_PIX_W = 8;

  // One extra bit over the address width so a full buffer (== DEPTH) is
  // representable without wrapping to zero.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/filter_stream_driver_ram.sv
// -----------------------------------------------------------------------------
// pixel_ram
// Single-clock simple dual-port frame buffer: one write port, one synchronous
// read port with one cycle of read latency.
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address, data appears on o_rd_data after the next edge
//   o_rd_data : registered read data
// -----------------------------------------------------------------------------
module pixel_ram #(
  parameter int DEPTH = 1024,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [PIX_W-1:0]         o_rd_data
);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rd_data;

  // NOTE: the storage array has no reset so it maps onto block RAM; its
  // contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/filter_stream_driver.sv
// -----------------------------------------------------------------------------
// filter_stream_driver
// Loads one frame of pixels from a host, streams it to a pixel filter with
// `enable`, then switches the filter to `enable_process` and forwards its
// results until `finish` or until N results have been captured.
//   clk, rst_n      : clock, synchronous active-low reset
//   load_valid/data : host pixel write, accepted while load_ready is high
//   load_ready      : buffer idle and not full
//   start           : stream the loaded frame (ignored when empty)
//   image_input     : pixel to the filter, qualified by enable
//   enable          : filter load phase
//   enable_process  : filter output phase
//   image_output    : filter result
//   finish          : filter end of output
//   res_valid/data  : captured filter result, no backpressure
//   busy            : SEND or PROC in progress
//   done            : one-cycle pulse at the end of a frame
// -----------------------------------------------------------------------------
module filter_stream_driver
  import filter_stream_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int OUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [PIX_W-1:0] load_data,
  output logic             load_ready,
  input  logic             start,
  output logic [PIX_W-1:0] image_input,
  output logic             enable,
  output logic             enable_process,
  input  logic [PIX_W-1:0] image_output,
  input  logic             finish,
  output logic             res_valid,
  output logic [PIX_W-1:0] res_data,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = (OUT_LAT > 0) ? $clog2(OUT_LAT + 1) : 1;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [LW-1:0] LAT_END = LW'(OUT_LAT);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  fsd_state_t       r_state;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_res_cnt;
  logic [PW-1:0]    r_len;
  logic [LW-1:0]    r_lat;
  logic             r_rd_v;        // RAM output holds a frame pixel this cycle
  logic [PIX_W-1:0] r_image_input;
  logic             r_enable;
  logic             r_enable_process;
  logic             r_res_valid;
  logic [PIX_W-1:0] r_res_data;
  logic             r_busy;
  logic             r_done;

  logic             w_load_ready;
  logic             w_wr_en;
  logic [PIX_W-1:0] w_rd_data;

  assign w_load_ready = (r_state == ST_IDLE) && (r_wr_ptr != DEPTH_P);
  assign w_wr_en      = w_load_ready && load_valid;

  pixel_ram #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (load_data),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_res_cnt        <= '0;
      r_len            <= '0;
      r_lat            <= '0;
      r_rd_v           <= 1'b0;
      r_image_input    <= '0;
      r_enable         <= 1'b0;
      r_enable_process <= 1'b0;
      r_res_valid      <= 1'b0;
      r_res_data       <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + ONE_P;
          end
          if (start && (r_wr_ptr != '0)) begin
            // A pixel written on the start cycle belongs to this frame.
            r_len    <= w_wr_en ? (r_wr_ptr + ONE_P) : r_wr_ptr;
            r_rd_ptr <= '0;
            r_state  <= ST_SEND;
            r_busy   <= 1'b1;
          end
        end

        ST_SEND: begin
          // Two-stage pipe: address issue -> RAM register -> output register.
          r_rd_v        <= (r_rd_ptr != r_len);
          if (r_rd_ptr != r_len) begin
            r_rd_ptr <= r_rd_ptr + ONE_P;
          end
          r_enable      <= r_rd_v;
          r_image_input <= r_rd_v ? w_rd_data : '0;
          // Pipe drained: enable drops on this edge, so hand over in lockstep.
          if ((r_rd_ptr == r_len) && !r_rd_v) begin
            r_state          <= ST_PROC;
            r_enable_process <= 1'b1;
            r_lat            <= '0;
          end
        end

        ST_PROC: begin
          if (r_lat != LAT_END) begin
            r_lat <= r_lat + ONE_L;
          end else if (finish) begin
            r_state          <= ST_DONE;
            r_enable_process <= 1'b0;
            r_busy           <= 1'b0;
          end else begin
            r_res_data  <= image_output;
            r_res_valid <= 1'b1;
            r_res_cnt   <= r_res_cnt + ONE_P;
            if ((r_res_cnt + ONE_P) == r_len) begin
              r_state          <= ST_DONE;
              r_enable_process <= 1'b0;
              r_busy           <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          r_done    <= 1'b1;
          r_wr_ptr  <= '0;
          r_rd_ptr  <= '0;
          r_res_cnt <= '0;
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready     = w_load_ready;
  assign image_input    = r_image_input;
  assign enable         = r_enable;
  assign enable_process = r_enable_process;
  assign res_valid      = r_res_valid;
  assign res_data       = r_res_data;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_filter_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_filter_stream_driver
// Drives frames into filter_stream_driver (DEPTH=8, OUT_LAT=1) with a
// behavioural brightness filter (+60 saturating, one cycle latency) attached.
// Expected pixel and result streams come from a table of frames whose
// expectations are written by hand or derived from the frame contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_filter_stream_driver;

  localparam int DEPTH   = 8;
  localparam int PIX_W   = 8;
  localparam int OUT_LAT = 1;
  localparam int NVEC    = 9;

  logic             clk          = 1'b0;
  logic             rst_n        = 1'b0;
  logic             load_valid   = 1'b0;
  logic [PIX_W-1:0] load_data    = '0;
  logic             start        = 1'b0;
  logic             finish       = 1'b0;
  logic [PIX_W-1:0] image_output = '0;
  logic             load_ready;
  logic [PIX_W-1:0] image_input;
  logic             enable;
  logic             enable_process;
  logic             res_valid;
  logic [PIX_W-1:0] res_data;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  filter_stream_driver #(
    .DEPTH   (DEPTH),
    .PIX_W   (PIX_W),
    .OUT_LAT (OUT_LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .start          (start),
    .image_input    (image_input),
    .enable         (enable),
    .enable_process (enable_process),
    .image_output   (image_output),
    .finish         (finish),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .busy           (busy),
    .done           (done)
  );

  function automatic logic [7:0] sat60(input logic [7:0] p);
    int s;
    s = int'(p) + 60;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  // Brightness filter: stores the pixels seen with enable, replays them +60
  // while enable_process is high, one cycle behind.
  logic [7:0] f_mem [$];
  int         f_idx  = 0;
  logic       f_en_d = 1'b0;

  always @(posedge clk) begin
    if (enable) begin
      if (!f_en_d) f_mem.delete();
      f_mem.push_back(image_input);
    end
    f_en_d <= enable;
    if (enable_process) begin
      image_output <= (f_idx < f_mem.size()) ? sat60(f_mem[f_idx]) : 8'd0;
      f_idx        <= f_idx + 1;
    end else begin
      f_idx <= 0;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct packed {
    logic [3:0]      n_load;
    logic [9:0][7:0] pix;
    logic [3:0]      fin_after;   // 0: no early finish
    logic            sis;         // pulse start while sending
    logic [3:0]      exp_acc;
    logic [3:0]      exp_nres;
    logic [7:0][7:0] exp_res;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input int n, input int fin, input bit sis, input int p[10],
                              input int e[8], input int acc, input int nres);
    vec_t v;
    v = '0;
    v.n_load    = 4'(n);
    v.fin_after = 4'(fin);
    v.sis       = sis;
    v.exp_acc   = 4'(acc);
    v.exp_nres  = 4'(nres);
    for (int i = 0; i < 10; i++) v.pix[i] = 8'(p[i]);
    for (int i = 0; i < 8; i++) v.exp_res[i] = 8'(e[i]);
    return v;
  endfunction

  // Reference: the buffer keeps the first DEPTH pixels, each result is the
  // filtered pixel, and an early finish truncates the result list.
  function automatic vec_t model(input int n, input int fin, input bit sis, input int p[10]);
    int e[8];
    int acc;
    acc = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < 8; i++) e[i] = (i < acc) ? int'(sat60(8'(p[i]))) : 0;
    return mk(n, fin, sis, p, e, acc, (fin > 0) ? fin : acc);
  endfunction

  task automatic run_frame(input int f, input vec_t v);
    int         k, acc, first_en, last_en, n_en, last_res, done_k, done_cnt;
    logic       both, prev_en, ep_fall;
    logic [7:0] en_q [$];
    logic [7:0] res_q [$];
    acc = 0; first_en = -1; last_en = -1; n_en = 0; last_res = -1;
    done_k = -1; done_cnt = 0; both = 1'b0; prev_en = 1'b0; ep_fall = 1'b0;

    for (int i = 0; i < int'(v.n_load); i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = v.pix[i];
      if (load_ready) acc++;
    end
    @(negedge clk);
    load_valid = 1'b0;
    check($sformatf("f%0d accepted", f), acc, v.exp_acc);
    check($sformatf("f%0d load_ready after load", f), load_ready, (v.exp_acc < DEPTH) ? 1 : 0);
    start = 1'b1;

    k = 0;
    while (done_cnt == 0 && k < 100) begin
      @(negedge clk);
      k++;
      if (enable) begin
        if (first_en < 0) first_en = k;
        last_en = k;
        n_en++;
        en_q.push_back(image_input);
      end
      if (enable && enable_process) both = 1'b1;
      if (prev_en && !enable) ep_fall = enable_process;
      if (res_valid) begin
        res_q.push_back(res_data);
        last_res = k;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (v.fin_after != 0 && res_q.size() >= int'(v.fin_after)) finish = 1'b1;
      start   = (v.sis && k == 5);
      prev_en = enable;
    end
    finish = 1'b0;
    start  = 1'b0;

    check($sformatf("f%0d done seen", f), done_cnt, 1);
    check($sformatf("f%0d first enable cycle", f), first_en, 3);
    check($sformatf("f%0d enable cycles", f), n_en, v.exp_acc);
    check($sformatf("f%0d enable contiguous", f), last_en - first_en + 1, v.exp_acc);
    for (int i = 0; i < en_q.size() && i < int'(v.exp_acc); i++)
      check($sformatf("f%0d image_input[%0d]", f, i), en_q[i], v.pix[i]);
    check($sformatf("f%0d enable_process at enable fall", f), ep_fall, 1);
    check($sformatf("f%0d enable and enable_process overlap", f), both, 0);
    check($sformatf("f%0d result count", f), res_q.size(), v.exp_nres);
    for (int i = 0; i < res_q.size() && i < int'(v.exp_nres); i++)
      check($sformatf("f%0d res_data[%0d]", f, i), res_q[i], v.exp_res[i]);
    check($sformatf("f%0d done timing", f), done_k - last_res, (v.fin_after != 0) ? 2 : 1);

    @(negedge clk);
    check($sformatf("f%0d done single pulse", f), done, 0);
    check($sformatf("f%0d busy after done", f), busy, 0);
    check($sformatf("f%0d load_ready after done", f), load_ready, 1);
    // Pointers were cleared, so a start without reloading must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("f%0d start after done ignored", f), {busy, enable}, 0);
  endtask

  initial begin
    int pa[10];
    int ea[8];
    int n, acc, fin;

    pa = '{10, 20, 30, 40, 0, 0, 0, 0, 0, 0};
    ea = '{70, 80, 90, 100, 0, 0, 0, 0};
    tbl[0] = mk(4, 0, 1'b0, pa, ea, 4, 4);
    pa = '{10, 20, 30, 250, 0, 0, 0, 0, 0, 0};
    ea = '{70, 80, 90, 255, 0, 0, 0, 0};
    tbl[1] = mk(4, 0, 1'b0, pa, ea, 4, 4);
    pa = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109};
    ea = '{160, 161, 162, 163, 164, 165, 166, 167};
    tbl[2] = mk(10, 0, 1'b1, pa, ea, 8, 8);
    pa = '{200, 195, 196, 1, 0, 0, 0, 0, 0, 0};
    ea = '{255, 255, 255, 61, 0, 0, 0, 0};
    tbl[3] = mk(4, 2, 1'b0, pa, ea, 4, 2);
    pa = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ea = '{60, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = mk(1, 0, 1'b0, pa, ea, 1, 1);
    for (int f = 5; f < NVEC; f++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < 10; i++) pa[i] = $urandom_range(0, 255);
      acc = (n > DEPTH) ? DEPTH : n;
      fin = (acc > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, acc - 1) : 0;
      tbl[f] = model(n, fin, 1'b0, pa);
    end

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    check("reset outputs zero",
          {image_input, enable, enable_process, res_valid, res_data, busy, done}, 0);
    check("reset load_ready", load_ready, 1);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("empty start busy", busy, 0);
    check("empty start enable", enable, 0);

    for (int f = 0; f < NVEC; f++) run_frame(f, tbl[f]);

    // Reset while the third pixel is on image_input.
    begin
      int n_en2, k2, done_seen;
      n_en2 = 0; k2 = 0; done_seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'(50 + i);
      end
      @(negedge clk);
      load_valid = 1'b0;
      start      = 1'b1;
      while (n_en2 < 3 && k2 < 20) begin
        @(negedge clk);
        start = 1'b0;
        k2++;
        if (enable) n_en2++;
      end
      check("mid-send reached pixel 3", n_en2, 3);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid-send reset enable", enable, 0);
      check("mid-send reset enable_process", enable_process, 0);
      check("mid-send reset busy", busy, 0);
      check("mid-send reset load_ready", load_ready, 1);
      check("mid-send reset done", done, 0);
      rst_n = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (done || enable || enable_process) done_seen = 1;
      end
      check("no activity after mid-send reset", done_seen, 0);
    end

    run_frame(NVEC, tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/filter_stream_driver.md
# filter_stream_driver

Hardware initiator for the pixel-filter streaming protocol. It replaces the file-driven bench loop in the lab datapath. A host side loads one frame of 8-bit pixels into an internal buffer. On `start`, the block streams the frame to a filter (such as the brightness filter) with `enable` high, then switches the filter to `enable_process`. It forwards the filter's `image_output` samples to a result port until the filter raises `finish` or the frame length is reached.

## Interface
Parameters:
- `DEPTH`, 1024: maximum frame length in pixels (power of two).
- `PIX_W`, 8: pixel width.
- `OUT_LAT`, 0: number of cycles after `enable_process` rises during which `image_output` is ignored.

Ports:
- `clk`  in  1  single clock; all state changes on the posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  host pixel is valid.
- `load_data`  in  PIX_W  host pixel.
- `load_ready`  out  1  buffer can accept a pixel.
- `start`  in  1  begin streaming the loaded frame.
- `image_input`  out  PIX_W  pixel to the filter.
- `enable`  out  1  filter load phase.
- `enable_process`  out  1  filter output phase.
- `image_output`  in  PIX_W  filter result.
- `finish`  in  1  filter end of output.
- `res_valid`  out  1  `res_data` is valid this cycle; no backpressure.
- `res_data`  out  PIX_W  captured filter result.
- `busy`  out  1  high in SEND or PROC.
- `done`  out  1  one-cycle pulse at the end of a frame.

## Operation
States: IDLE, SEND, PROC, DONE.

- **Reset:**
  - State is IDLE; `wr_ptr`, `rd_ptr` and `res_cnt` are 0.
  - Every output is 0 except `load_ready`, which is 1.
  - Buffer contents are don't-care.
- **IDLE:**
  - `load_ready` = (`wr_ptr` != DEPTH).
  - When `load_valid` && `load_ready`, write `load_data` to `buf[wr_ptr]` and increment `wr_ptr`.
  - When the buffer is full, writes are dropped with no error.
- **IDLE to SEND:**
  - Transition on `start` with `wr_ptr` > 0; latch N = `wr_ptr`.
  - A write accepted in the same cycle as `start` is counted in N.
  - `start` with `wr_ptr` == 0 is ignored.
- **SEND:**
  - `load_ready` = 0.
  - Pixels `buf[0..N-1]` appear on `image_input` on N consecutive cycles, with `enable` = 1 on exactly those cycles.
  - `start` and `load_valid` are ignored.
- **SEND to PROC:**
  - On the cycle after the last pixel, `enable` falls and `enable_process` rises on the same cycle.
  - `image_input` returns to 0.
- **PROC:**
  - `enable_process` = 1.
  - The first `OUT_LAT` cycles are skipped.
  - After that, on each cycle with `finish` == 0: `res_data` <= `image_output`, `res_valid` <= 1, `res_cnt`++.
  - Leave PROC when `finish` == 1 (that cycle's sample is not captured), or when `res_cnt` reaches N. `finish` takes priority if both occur together.
- **DONE:**
  - `enable_process` = 0 and `done` = 1 for one cycle.
  - `wr_ptr`, `rd_ptr` and `res_cnt` are cleared, so the next frame must be reloaded.
  - Next state is IDLE.
- **Reset mid-operation:** on the next edge, return to IDLE with reset values. No `done` is emitted.
- **Widths:**
  - Pointers and counters are clog2(DEPTH)+1 bits, so they can hold the value DEPTH.
  - Data passes through unmodified; no arithmetic is applied to pixels.

## Timing
- Write latency: a pixel accepted at edge t is readable from edge t+1.
- Start latency: with `start` sampled at edge t, `enable` and `buf[0]` are first seen after edge t+2. One cycle is used for the synchronous RAM prefetch; `image_input` and `enable` are registered together.
- Pixel k is presented after edge t+2+k. `enable_process` rises after edge t+2+N.
- Result latency: `image_output` sampled at edge e appears on `res_data`/`res_valid` after edge e (one registered stage).
- `done` is asserted on the cycle after the last capture or the `finish` edge.
- `busy` is registered and equals (state ∈ {SEND, PROC}).
- `enable` and `enable_process` are never both high.

## Structure
- Package `filter_stream_pkg`:
  - State enum `fsd_state_t`.
  - `PIX_W` default.
  - Helper function `ptr_w(DEPTH)`.
- Sub-module `pixel_ram`:
  - Single-clock simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency, no reset.
  - It is the only storage; the FSM, pointers and output registers live in the top level.

## Test plan
1. **Reset:** assert `rst_n`=0 for 3 cycles → all outputs 0, `load_ready`=1; `start` with an empty buffer → stays IDLE, `busy`=0.
2. **Basic frame:**
   - Load 10,20,30,40, then pulse `start`.
   - `enable` is high for exactly 4 cycles carrying 10,20,30,40, beginning 2 cycles after `start`.
   - `enable_process` rises the cycle `enable` falls.
3. **Filter model:**
   - Model: +60 saturating at 255, 1-cycle latency, `OUT_LAT`=1; inputs 10,20,30,250.
   - `res_data` = 70,80,90,255 on 4 `res_valid` cycles, then a single `done` pulse, then IDLE.
4. **Full buffer:**
   - Set `DEPTH`=8 and offer 10 writes → `load_ready` goes low after 8; writes 9–10 are dropped.
   - `start` sends 8 pixels; `start` asserted during SEND has no effect.
5. **Early finish:** `finish`=1 after 2 results of a 4-pixel frame → exactly 2 `res_valid` cycles, `done` pulse, `wr_ptr` cleared.
6. **Reset mid-SEND:** `rst_n`=0 during pixel 3 → next cycle `enable`=0, `enable_process`=0, `busy`=0, `load_ready`=1, no `done`.
